// File: rtl/joy_scan_sequencer.sv
// joy_scan_sequencer: drives a 16-bit PISO joystick chain, shifts in frames and
// publishes a frame only when it matches the previous raw frame.
module joy_scan_sequencer #(
  parameter int CLK_DIV   = 8,
  parameter int NBITS     = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scan_en_i,
  input  logic       scan_req_i,
  input  logic       joy_data_i,
  output logic       joy_clk_o,
  output logic       joy_load_o,
  output logic [7:0] joy1_o,
  output logic [7:0] joy2_o,
  output logic       frame_valid_o,
  output logic       busy_o,
  output logic [7:0] frame_cnt_o
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int KW = $clog2(NBITS);
  localparam int GW = $clog2(GAP_TICKS + 2);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [KW-1:0]    k_q, k_d;
  logic [GW-1:0]    g_q, g_d;
  logic             joy_clk_q, joy_clk_d, pend_q, pend_d, valid_q, valid_d;
  logic [NBITS-1:0] raw_q, raw_d, prev_q, prev_d;
  logic [7:0]       joy1_q, joy1_d, joy2_q, joy2_d, cnt_q, cnt_d;
  logic             tick, rise, start, last;
  always_comb begin
    tick      = div_q == DW'(CLK_DIV - 1);
    rise      = tick & ~joy_clk_q;
    start     = scan_en_i | pend_q;
    last      = rise && state_q == SHIFT && k_q == KW'(NBITS - 1);
    div_d     = tick ? '0 : div_q + DW'(1);
    joy_clk_d = joy_clk_q ^ tick;
    state_d   = state_q;
    k_d       = k_q;
    g_d       = g_q;
    raw_d     = raw_q;
    if (rise) begin
      case (state_q)
        IDLE:  state_d = start ? LOAD : IDLE;
        LOAD: begin
          state_d = SHIFT;
          k_d     = '0;
        end
        SHIFT: begin
          raw_d[KW'(NBITS - 1) - k_q] = joy_data_i;
          k_d = k_q + KW'(1);
          if (last) begin
            g_d     = '0;
            state_d = (GAP_TICKS == 0) ? (start ? LOAD : IDLE) : GAP;
          end
        end
        default: begin
          g_d = g_q + GW'(1);
          if (g_d == GW'(GAP_TICKS)) state_d = start ? LOAD : IDLE;
        end
      endcase
    end
    // a request landing on the LOAD-entry edge stays pending for the next frame
    pend_d  = scan_req_i | (pend_q & ~(state_d == LOAD && state_q != LOAD));
    cnt_d   = cnt_q + 8'(last);
    valid_d = last && raw_d == prev_q;
    joy1_d  = valid_d ? raw_d[15:8] : joy1_q;
    joy2_d  = valid_d ? raw_d[7:0] : joy2_q;
    prev_d  = last ? raw_d : prev_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      k_q       <= '0;
      g_q       <= '0;
      joy_clk_q <= 1'b0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      raw_q     <= '1;
      prev_q    <= '1;
      joy1_q    <= '1;
      joy2_q    <= '1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      k_q       <= k_d;
      g_q       <= g_d;
      joy_clk_q <= joy_clk_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      joy1_q    <= joy1_d;
      joy2_q    <= joy2_d;
      cnt_q     <= cnt_d;
    end
  end
  assign joy_clk_o     = joy_clk_q;
  assign joy_load_o    = state_q != LOAD;
  assign busy_o        = state_q != IDLE;
  assign joy1_o        = joy1_q;
  assign joy2_o        = joy2_q;
  assign frame_valid_o = valid_q;
  assign frame_cnt_o   = cnt_q;
endmodule

// File: tb/tb_joy_scan_sequencer.sv
// tb_joy_scan_sequencer: table-driven frame scoreboard against two configurations
// (defaults, and CLK_DIV=1/GAP_TICKS=0) each fed by a 74HC165-style chain model.
module tb_joy_scan_sequencer;
  typedef struct {
    logic [7:0] j1, j2;
    logic       v;
    logic [7:0] e1, e2;
  } vec_t;
  logic clk = 0, rst = 1, en = 0, req = 0, en_f = 0, req_f = 0;
  logic jclk, jload, fv, busy, jclk_f, jload_f, fv_f, busy_f;
  logic [7:0] j1, j2, cnt, j1_f, j2_f, cnt_f;
  logic [15:0] chain_d = 16'hFFFF, chain_f = 16'hFFFF, sr_d = 16'hFFFF, sr_f = 16'hFFFF;
  logic cp_d = 0, lp_d = 1, cp_f = 0, lp_f = 1;
  int run_d = 0, len_d = 0, run_f = 0, len_f = 0, pulses_d = 0;
  int total = 0, bad = 0;
  vec_t tbl[9];
  vec_t ftbl[4];
  vec_t sb[$];
  always #5 clk = ~clk;
  joy_scan_sequencer u_dut (
    .clk_i(clk), .rst_i(rst), .scan_en_i(en), .scan_req_i(req), .joy_data_i(sr_d[15]),
    .joy_clk_o(jclk), .joy_load_o(jload), .joy1_o(j1), .joy2_o(j2),
    .frame_valid_o(fv), .busy_o(busy), .frame_cnt_o(cnt)
  );
  joy_scan_sequencer #(.CLK_DIV(1), .GAP_TICKS(0)) u_fast (
    .clk_i(clk), .rst_i(rst), .scan_en_i(en_f), .scan_req_i(req_f), .joy_data_i(sr_f[15]),
    .joy_clk_o(jclk_f), .joy_load_o(jload_f), .joy1_o(j1_f), .joy2_o(j2_f),
    .frame_valid_o(fv_f), .busy_o(busy_f), .frame_cnt_o(cnt_f)
  );
  // chain: parallel load while strobe low; shift on a joy_clk rise only once load has been high
  always @(posedge clk) begin
    cp_d <= jclk;
    lp_d <= jload;
    if (!jload) sr_d <= chain_d;
    else if (jclk && !cp_d && lp_d) sr_d <= {sr_d[14:0], 1'b1};
    cp_f <= jclk_f;
    lp_f <= jload_f;
    if (!jload_f) sr_f <= chain_f;
    else if (jclk_f && !cp_f && lp_f) sr_f <= {sr_f[14:0], 1'b1};
  end
  always @(negedge clk) begin
    if (!jload) run_d <= run_d + 1;
    else begin
      if (run_d != 0) len_d <= run_d;
      run_d <= 0;
    end
    if (!jload_f) run_f <= run_f + 1;
    else begin
      if (run_f != 0) len_f <= run_f;
      run_f <= 0;
    end
    if (fv) pulses_d <= pulses_d + 1;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask
  task automatic wait_frame(input bit fast, output bit ok, output int cyc);
    logic [7:0] c0;
    c0 = fast ? cnt_f : cnt;
    ok = 0;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if ((fast ? cnt_f : cnt) != c0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: no frame end within %0d cycles, required one", cyc);
    end
  endtask
  task automatic wait_sig(input bit which, input logic val);
    bit hit;
    hit = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((which ? jclk : jload) == val) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_sig: signal %0d never reached %0b", which, val);
    end
  endtask
  initial begin
    vec_t e;
    bit ok;
    int cyc, first, loads, tog, p0;
    logic prev;
    tbl[0] = '{8'hFE, 8'h7F, 1'b0, 8'hFF, 8'hFF};
    tbl[1] = '{8'hFE, 8'h7F, 1'b1, 8'hFE, 8'h7F};
    tbl[2] = '{8'hF7, 8'h7F, 1'b0, 8'hFE, 8'h7F};
    tbl[3] = '{8'hFE, 8'h7F, 1'b0, 8'hFE, 8'h7F};
    tbl[4] = '{8'hFE, 8'h7F, 1'b1, 8'hFE, 8'h7F};
    tbl[5] = '{8'h00, 8'hFF, 1'b0, 8'hFE, 8'h7F};
    tbl[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF};
    tbl[7] = '{8'hA5, 8'h3C, 1'b0, 8'h00, 8'hFF};
    tbl[8] = '{8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C};
    ftbl[0] = '{8'h96, 8'h3A, 1'b0, 8'hFF, 8'hFF};
    ftbl[1] = '{8'h96, 8'h3A, 1'b1, 8'h96, 8'h3A};
    ftbl[2] = '{8'h3A, 8'h96, 1'b0, 8'h96, 8'h3A};
    ftbl[3] = '{8'h3A, 8'h96, 1'b1, 8'h3A, 8'h96};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_jclk", 32'(jclk), 32'd0);
    chk("rst_jload", 32'(jload), 32'd1);
    chk("rst_joy1", 32'(j1), 32'hFF);
    chk("rst_joy2", 32'(j2), 32'hFF);
    chk("rst_valid", 32'(fv), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst = 0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (jclk) begin
        first = i;
        break;
      end
    end
    chk("first_rise", 32'(first), 32'd8);
    loads = 0;
    tog = 0;
    prev = jclk_f;
    repeat (100) begin
      @(negedge clk);
      if (!jload) loads++;
      if (jclk_f != prev) tog++;
      prev = jclk_f;
    end
    chk("idle_no_load", 32'(loads), 32'd0);
    chk("fast_toggle", 32'(tog), 32'd100);
    chain_d = {tbl[0].j1, tbl[0].j2};
    sb.push_back(tbl[0]);
    en = 1;
    for (int i = 0; i < 9; i++) begin
      wait_frame(0, ok, cyc);
      if (ok) begin
        e = sb.pop_front();
        chk($sformatf("f%0d_valid", i), 32'(fv), 32'(e.v));
        chk($sformatf("f%0d_joy1", i), 32'(j1), 32'(e.e1));
        chk($sformatf("f%0d_joy2", i), 32'(j2), 32'(e.e2));
        chk($sformatf("f%0d_cnt", i), 32'(cnt), 32'(i + 1));
        chk($sformatf("f%0d_loadlen", i), 32'(len_d), 32'd16);
        if (i > 0) chk($sformatf("f%0d_period", i), 32'(cyc), 32'd304);
        if (i < 8) begin
          chain_d = {tbl[i+1].j1, tbl[i+1].j2};
          sb.push_back(tbl[i+1]);
        end
      end
    end
    en = 0;
    repeat (400) @(negedge clk);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_cnt", 32'(cnt), 32'd9);
    // one request starts a frame; two more during it merge into one extra frame
    e = '{8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C};
    sb.push_back(e);
    sb.push_back(e);
    req = 1;
    @(negedge clk);
    req = 0;
    repeat (100) @(negedge clk);
    chk("req_busy", 32'(busy), 32'd1);
    req = 1;
    @(negedge clk);
    req = 0;
    repeat (50) @(negedge clk);
    req = 1;
    @(negedge clk);
    req = 0;
    for (int i = 0; i < 2; i++) begin
      wait_frame(0, ok, cyc);
      if (ok) begin
        e = sb.pop_front();
        chk($sformatf("req%0d_valid", i), 32'(fv), 32'(e.v));
        chk($sformatf("req%0d_joy1", i), 32'(j1), 32'(e.e1));
        chk($sformatf("req%0d_cnt", i), 32'(cnt), 32'(10 + i));
        if (i > 0) chk("req_from_gap", 32'(cyc), 32'd304);
      end
    end
    repeat (400) @(negedge clk);
    chk("req_done_busy", 32'(busy), 32'd0);
    chk("req_done_cnt", 32'(cnt), 32'd11);
    en = 1;
    wait_sig(0, 1'b0);
    wait_sig(0, 1'b1);
    repeat (5) begin
      wait_sig(1, 1'b0);
      wait_sig(1, 1'b1);
    end
    rst = 1;
    @(negedge clk);
    chk("mid_rst_jload", 32'(jload), 32'd1);
    chk("mid_rst_jclk", 32'(jclk), 32'd0);
    chk("mid_rst_joy1", 32'(j1), 32'hFF);
    chk("mid_rst_joy2", 32'(j2), 32'hFF);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 0;
    en = 0;
    p0 = pulses_d;
    repeat (400) @(negedge clk);
    chk("mid_rst_no_valid", 32'(pulses_d - p0), 32'd0);
    chk("mid_rst_cnt_after", 32'(cnt), 32'd0);
    chain_f = {ftbl[0].j1, ftbl[0].j2};
    sb.push_back(ftbl[0]);
    en_f = 1;
    for (int i = 0; i < 4; i++) begin
      wait_frame(1, ok, cyc);
      if (ok) begin
        e = sb.pop_front();
        chk($sformatf("fast%0d_valid", i), 32'(fv_f), 32'(e.v));
        chk($sformatf("fast%0d_joy1", i), 32'(j1_f), 32'(e.e1));
        chk($sformatf("fast%0d_joy2", i), 32'(j2_f), 32'(e.e2));
        chk($sformatf("fast%0d_cnt", i), 32'(cnt_f), 32'(i + 1));
        if (i > 0) begin
          chk($sformatf("fast%0d_period", i), 32'(cyc), 32'd34);
          chk($sformatf("fast%0d_loadlen", i), 32'(len_f), 32'd2);
        end
        if (i < 3) begin
          chain_f = {ftbl[i+1].j1, ftbl[i+1].j2};
          sb.push_back(ftbl[i+1]);
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
